// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter slice.
//   LINE_W / ADDR_W   : memory line and byte-address widths
//   lc3b_line / _word : line and address types
//   mem_arb_state_t   : arbiter FSM states
package lc3b_types;
    localparam int LINE_W = 128;
    localparam int ADDR_W = 16;

    typedef logic [LINE_W-1:0] lc3b_line;
    typedef logic [ADDR_W-1:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } mem_arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Read/write/resp memory handshake shared by the fetch port, the data
// port and the physical memory port.
//   read, write, address, wdata : request side, driven by the master
//   rdata, resp                 : completion side, driven by the slave
// master = the side that issues requests; slave = the side that serves them.
interface mem_port_arbiter_if;
    import lc3b_types::*;

    logic     read;
    logic     write;
    lc3b_word address;
    lc3b_line wdata;
    lc3b_line rdata;
    logic     resp;

    modport master (output read, write, address, wdata, input  rdata, resp);
    modport slave  (input  read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select for the memory port arbiter.
//   i_req      : fetch requester active
//   d_req      : data requester active
//   last_grant : 1 when data held the port last (round-robin build only)
//   grant_d    : 1 selects data, 0 selects fetch (only meaningful with a request)
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate on ties instead of fixed
// data-over-fetch priority.
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_d
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not hold the port last wins.
    assign grant_d = d_req & (~i_req | ~last_grant);
`else
    // Fixed priority: data always wins; fetch may starve under data traffic.
    logic unused_pick;
    assign unused_pick = i_req ^ last_grant;
    assign grant_d     = d_req;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between the fetch and data requesters.
// All outputs are registered; the granted requester gets a one-cycle resp
// pulse with the captured line one cycle after pmem resp.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_bus        : fetch requester (read-only; write/wdata unused)
//   d_bus        : data requester (read and write; both set means write)
//   pmem_bus     : physical memory port
// Build option MEM_ARB_ROUND_ROBIN_EN adds a last_grant register and
// round-robin tie breaking (see mem_arb_pick).
//
// state   | meaning
// IDLE    | no transaction; a request here is granted at this edge
// GRANT_I | fetch owns pmem, strobe held until pmem resp
// GRANT_D | data owns pmem, strobe held until pmem resp
// DONE    | resp pulse to the owner; requests ignored for this cycle
module mem_port_arbiter
    import lc3b_types::*;
(
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  i_bus,
    mem_port_arbiter_if.slave  d_bus,
    mem_port_arbiter_if.master pmem_bus
);
    mem_arb_state_t state, state_next;

    logic     read_q,  read_next;
    logic     write_q, write_next;
    lc3b_word addr_q,  addr_next;
    lc3b_line wdata_q, wdata_next;
    logic     i_resp_q, i_resp_next;
    logic     d_resp_q, d_resp_next;
    lc3b_line i_rdata_q, d_rdata_q;
    logic     cap_i, cap_d, grant_evt;

    logic i_req, d_req, grant_d, last_grant;

    assign i_req = i_bus.read;
    assign d_req = d_bus.read | d_bus.write;

    // The fetch side is read-only; its write lines carry nothing.
    logic unused_fetch;
    assign unused_fetch = ^{i_bus.write, i_bus.wdata};

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant_d    (grant_d)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_grant=1 means data held the port last; it resets to 1 so that
    // fetch takes the first tie after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_grant <= 1'b1;
        else if (grant_evt)
            last_grant <= grant_d;
    end
`else
    assign last_grant = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        read_next   = read_q;
        write_next  = write_q;
        addr_next   = addr_q;
        wdata_next  = wdata_q;
        i_resp_next = 1'b0;
        d_resp_next = 1'b0;
        cap_i       = 1'b0;
        cap_d       = 1'b0;
        grant_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_evt = 1'b1;
                    if (grant_d) begin
                        state_next = GRANT_D;
                        write_next = d_bus.write;
                        read_next  = ~d_bus.write;
                        addr_next  = d_bus.address;
                        wdata_next = d_bus.wdata;
                    end else begin
                        state_next = GRANT_I;
                        write_next = 1'b0;
                        read_next  = 1'b1;
                        addr_next  = i_bus.address;
                        wdata_next = '0;
                    end
                end
            end
            GRANT_I: begin
                if (pmem_bus.resp) begin
                    state_next  = DONE;
                    read_next   = 1'b0;
                    write_next  = 1'b0;
                    i_resp_next = 1'b1;
                    cap_i       = 1'b1;
                end
            end
            GRANT_D: begin
                if (pmem_bus.resp) begin
                    state_next  = DONE;
                    read_next   = 1'b0;
                    write_next  = 1'b0;
                    d_resp_next = 1'b1;
                    cap_d       = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_resp_q  <= 1'b0;
            d_resp_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state    <= state_next;
            read_q   <= read_next;
            write_q  <= write_next;
            addr_q   <= addr_next;
            wdata_q  <= wdata_next;
            i_resp_q <= i_resp_next;
            d_resp_q <= d_resp_next;
            if (cap_i) i_rdata_q <= pmem_bus.rdata;
            if (cap_d) d_rdata_q <= pmem_bus.rdata;
        end
    end

    assign pmem_bus.read    = read_q;
    assign pmem_bus.write   = write_q;
    assign pmem_bus.address = addr_q;
    assign pmem_bus.wdata   = wdata_q;
    assign i_bus.resp       = i_resp_q;
    assign i_bus.rdata      = i_rdata_q;
    assign d_bus.resp       = d_resp_q;
    assign d_bus.rdata      = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed transactions plus
// randomized request mixes, checked against a transaction-level model of
// the arbitration rules. Inputs change and outputs are sampled on negedge.
module tb_mem_port_arbiter;
    import lc3b_types::*;

    logic clk;
    logic reset_n;

    mem_port_arbiter_if i_bus ();
    mem_port_arbiter_if d_bus ();
    mem_port_arbiter_if pmem_bus ();

    mem_port_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_bus    (i_bus),
        .d_bus    (d_bus),
        .pmem_bus (pmem_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Model state: who held the port last (1 = data), and the lines each
    // requester should currently be showing.
    bit       last_d;
    lc3b_line exp_i_rdata;
    lc3b_line exp_d_rdata;
    bit       exp_d_valid;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic lc3b_line rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Arbitration rule: a lone requester wins; on a tie data wins in the
    // fixed build, and the one not served last wins in the round-robin build.
    function automatic bit model_pick(input bit pi, input bit pd);
        bit w;
        if (pi && pd) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = !last_d;
`else
            w = 1'b1;
`endif
        end else begin
            w = pd;
        end
        last_d = w;
        return w;
    endfunction

    // One scenario: raise the chosen requests in IDLE, then serve every
    // grant with the given memory latencies and check each step.
    task automatic run_scen(input bit ri, input bit dr, input bit dw, input bit late_d,
                            input lc3b_word ia, input lc3b_word da, input lc3b_line dwd,
                            input int lat_a, input int lat_b);
        bit       pend_i, pend_d, w, late, exp_rd, exp_wr;
        lc3b_word exp_addr;
        lc3b_line rnd;
        int       lat;
        late = late_d & ri & (dr | dw);
        i_bus.read    = ri;
        i_bus.address = ia;
        d_bus.read    = dr & ~late;
        d_bus.write   = dw & ~late;
        d_bus.address = da;
        d_bus.wdata   = dwd;
        pend_i = ri;
        pend_d = (dr | dw) & ~late;
        for (int n = 0; n < 2; n++) begin
            if (!(pend_i || pend_d)) break;
            w = model_pick(pend_i, pend_d);
            if (n > 0) begin
                @(negedge clk);
                check("gap_strobe", {pmem_bus.read, pmem_bus.write}, 2'b00);
            end
            @(negedge clk);
            exp_rd   = w ? (dr & ~dw) : 1'b1;
            exp_wr   = w & dw;
            exp_addr = w ? da : ia;
            check("grant_op", {pmem_bus.read, pmem_bus.write}, {exp_rd, exp_wr});
            check("grant_addr", pmem_bus.address, exp_addr);
            if (exp_wr) check("grant_wdata", pmem_bus.wdata, dwd);
            if (late && n == 0) begin
                d_bus.read  = dr;
                d_bus.write = dw;
                pend_d      = 1'b1;
            end
            lat = (n == 0) ? lat_a : lat_b;
            for (int k = 0; k < lat; k++) begin
                pmem_bus.rdata = rand_line();
                @(negedge clk);
                check("hold_op", {pmem_bus.read, pmem_bus.write}, {exp_rd, exp_wr});
                check("hold_addr", pmem_bus.address, exp_addr);
                if (exp_wr) check("hold_wdata", pmem_bus.wdata, dwd);
                check("hold_resp", {i_bus.resp, d_bus.resp}, 2'b00);
            end
            rnd            = rand_line();
            pmem_bus.rdata = rnd;
            pmem_bus.resp  = 1'b1;
            @(negedge clk);
            pmem_bus.resp  = 1'b0;
            pmem_bus.rdata = rand_line();
            check("done_strobe", {pmem_bus.read, pmem_bus.write}, 2'b00);
            check("done_resp", {i_bus.resp, d_bus.resp}, w ? 2'b01 : 2'b10);
            if (w) begin
                if (!exp_wr) check("d_rdata", d_bus.rdata, rnd);
                exp_d_rdata = rnd;
                exp_d_valid = !exp_wr;
                check("i_rdata_kept", i_bus.rdata, exp_i_rdata);
                d_bus.read  = 1'b0;
                d_bus.write = 1'b0;
                pend_d      = 1'b0;
            end else begin
                check("i_rdata", i_bus.rdata, rnd);
                exp_i_rdata = rnd;
                if (exp_d_valid) check("d_rdata_kept", d_bus.rdata, exp_d_rdata);
                i_bus.read = 1'b0;
                pend_i     = 1'b0;
            end
        end
        @(negedge clk);
        check("post_resp", {i_bus.resp, d_bus.resp}, 2'b00);
        check("post_strobe", {pmem_bus.read, pmem_bus.write}, 2'b00);
        @(negedge clk);
        check("idle_strobe", {pmem_bus.read, pmem_bus.write}, 2'b00);
    endtask

    initial begin
        bit       ri, late;
        int       dsel;
        lc3b_line wd;

        reset_n          = 1'b0;
        i_bus.read       = 1'b0;
        i_bus.write      = 1'b0;
        i_bus.address    = '0;
        i_bus.wdata      = '0;
        d_bus.read       = 1'b0;
        d_bus.write      = 1'b0;
        d_bus.address    = '0;
        d_bus.wdata      = '0;
        pmem_bus.resp    = 1'b0;
        pmem_bus.rdata   = '0;
        last_d           = 1'b1;
        exp_i_rdata      = '0;
        exp_d_rdata      = '0;
        exp_d_valid      = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_strobe", {pmem_bus.read, pmem_bus.write}, 2'b00);
        check("rst_addr", pmem_bus.address, 16'h0);
        check("rst_wdata", pmem_bus.wdata, '0);
        check("rst_resp", {i_bus.resp, d_bus.resp}, 2'b00);
        check("rst_i_rdata", i_bus.rdata, '0);
        check("rst_d_rdata", d_bus.rdata, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Simultaneous reads held, three times: order follows the build's rule.
        for (int r = 0; r < 3; r++)
            run_scen(1'b1, 1'b1, 1'b0, 1'b0, 16'h2000 + 16'(r), 16'h3000 + 16'(r), '0, 1, 2);

        // Single fetch, memory answers two cycles after the strobe.
        run_scen(1'b1, 1'b0, 1'b0, 1'b0, 16'h1230, 16'h0, '0, 2, 0);
        // Data write, zero-wait memory.
        run_scen(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h4000, {8{16'h5555}}, 0, 0);
        // Read and write together count as a write.
        run_scen(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h4010, {4{32'hdeadbeef}}, 1, 0);

        // Stray pmem resp in IDLE must do nothing.
        pmem_bus.resp  = 1'b1;
        pmem_bus.rdata = rand_line();
        @(negedge clk);
        pmem_bus.resp = 1'b0;
        check("stray_resp", {i_bus.resp, d_bus.resp}, 2'b00);
        check("stray_strobe", {pmem_bus.read, pmem_bus.write}, 2'b00);
        check("stray_i_rdata", i_bus.rdata, exp_i_rdata);
        @(negedge clk);
        check("stray_resp2", {i_bus.resp, d_bus.resp}, 2'b00);
        run_scen(1'b1, 1'b1, 1'b0, 1'b0, 16'h5000, 16'h6000, '0, 0, 1);

        // Reset while data owns the port with the write strobe high.
        wd            = rand_line();
        d_bus.write   = 1'b1;
        d_bus.read    = 1'b0;
        d_bus.address = 16'h7777;
        d_bus.wdata   = wd;
        @(negedge clk);
        check("pre_rst_write", pmem_bus.write, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_write", pmem_bus.write, 1'b0);
        check("rst_async_addr", pmem_bus.address, 16'h0);
        check("rst_async_wdata", pmem_bus.wdata, '0);
        last_d      = 1'b1;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        exp_d_valid = 1'b1;
        pmem_bus.resp = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_resp", {i_bus.resp, d_bus.resp}, 2'b00);
            check("rst_hold_rdata", d_bus.rdata, '0);
        end
        pmem_bus.resp = 1'b0;
        reset_n = 1'b1;
        run_scen(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h7777, wd, 1, 0);

        // Randomized request mixes and memory latencies.
        for (int t = 0; t < 60; t++) begin
            ri   = 1'($urandom_range(0, 1));
            dsel = int'($urandom_range(0, 3));
            if (!ri && dsel == 0) ri = 1'b1;
            late = ($urandom_range(0, 3) == 0);
            run_scen(ri, dsel[0], dsel[1], late, 16'($urandom()), 16'($urandom()),
                     rand_line(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
